// File: rtl/riscz_pkg.sv
// Shared RISC-Z front-end definitions: PC-select encodings used by branch
// control and the PC sequencer, plus the sequencer state type.
package riscz_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b10;
    localparam logic [1:0] PCSEL_JR  = 2'b01;
    localparam logic [1:0] PCSEL_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } seq_state_t;

endpackage

// File: rtl/pc_flush_timer.sv
// Loadable down-counter that times the wrong-path kill window after a redirect.
module pc_flush_timer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic flush_active,
    output logic flush_done
);

    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES);

    logic [2:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= RELOAD;
        else if (cnt != '0)
            cnt <= cnt - 3'd1;
    end

    assign flush_active = (cnt != '0);
    // Last kill cycle; a same-cycle reload takes precedence in the counter.
    assign flush_done   = (cnt == 3'd1);

endmodule

// File: rtl/pc_sequencer.sv
// RISC-Z program-counter sequencer: PC register, fetch request generation,
// and redirect handling with a timed flush window.
module pc_sequencer
    import riscz_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel_valid,
    input  logic [1:0]          pc_sel,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic [PC_WIDTH-1:0] jr_target,
    input  logic                stall,
    input  logic                fetch_ready,
    output logic                fetch_req,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] link_pc,
    output logic                flush
);

    seq_state_t          state;
    logic                redirect;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                flush_active;
    logic                flush_done;

    always_comb begin
        redirect = 1'b0;
        target   = br_target;
        if (sel_valid && state != IDLE) begin
            if (pc_sel == PCSEL_BR) begin
                redirect = 1'b1;
                target   = br_target;
            end else if (pc_sel == PCSEL_JR) begin
                redirect = 1'b1;
                target   = jr_target;
            end
        end
    end

    assign pc_inc    = pc + PC_WIDTH'(1);
    assign fetch_req = (state == FETCH) && !stall;

    pc_flush_timer #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (redirect),
        .flush_active(flush_active),
        .flush_done  (flush_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            link_pc <= RESET_PC;
            flush   <= 1'b0;
        end else if (redirect) begin
            state <= FLUSH;
            pc    <= target;
            flush <= 1'b1;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (fetch_req && fetch_ready) begin
                        pc      <= pc_inc;
                        link_pc <= pc_inc;
                    end
                end
                FLUSH: begin
                    // An idle timer here cannot happen, but never leave the sequencer stuck.
                    if (flush_done || !flush_active) begin
                        state <= FETCH;
                        flush <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (PC_WIDTH=16, RESET_PC=0, FLUSH_CYCLES=2).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_valid;
    logic [1:0]  pc_sel;
    logic [15:0] br_target;
    logic [15:0] jr_target;
    logic        stall;
    logic        fetch_ready;
    logic        fetch_req;
    logic [15:0] pc;
    logic [15:0] link_pc;
    logic        flush;

    int unsigned total  = 0;
    int unsigned passed = 0;

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic [15:0] link;
        logic        req;
        logic        fl;
    } exp_t;

    exp_t sbq[$];

    pc_sequencer #(
        .PC_WIDTH    (16),
        .RESET_PC    (16'h0000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_valid  (sel_valid),
        .pc_sel     (pc_sel),
        .br_target  (br_target),
        .jr_target  (jr_target),
        .stall      (stall),
        .fetch_ready(fetch_ready),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .link_pc    (link_pc),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive this cycle's inputs at the falling edge, check this cycle's outputs, then cross a rising edge.
    task automatic step(input string tag, input logic r, input logic sv, input logic [1:0] sel,
                        input logic [15:0] br, input logic [15:0] jr, input logic st, input logic rdy,
                        input logic [15:0] epc, input logic [15:0] elink, input logic ereq, input logic efl);
        exp_t e;
        e.tag = tag; e.pc = epc; e.link = elink; e.req = ereq; e.fl = efl;
        sbq.push_back(e);
        rst = r; sel_valid = sv; pc_sel = sel; br_target = br; jr_target = jr;
        stall = st; fetch_ready = rdy;
        #1;
        e = sbq.pop_front();
        total++;
        assert (pc === e.pc) passed++;
        else $error("FAIL %s.pc observed=%h expected=%h", e.tag, pc, e.pc);
        total++;
        assert (link_pc === e.link) passed++;
        else $error("FAIL %s.link_pc observed=%h expected=%h", e.tag, link_pc, e.link);
        total++;
        assert (fetch_req === e.req) passed++;
        else $error("FAIL %s.fetch_req observed=%b expected=%b", e.tag, fetch_req, e.req);
        total++;
        assert (flush === e.fl) passed++;
        else $error("FAIL %s.flush observed=%b expected=%b", e.tag, flush, e.fl);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sel_valid = 1'b0; pc_sel = 2'b00; br_target = '0; jr_target = '0;
        stall = 1'b0; fetch_ready = 1'b0;
        @(negedge clk);

        // Reset then sequential run
        step("rst_idle", 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 0);
        step("run0",     0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 1, 0);
        step("run1",     0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0001, 16'h0001, 1, 0);
        step("run2",     0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0002, 16'h0002, 1, 0);
        step("run3",     0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0003, 16'h0003, 1, 0);
        step("run4",     0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0004, 16'h0004, 1, 0);

        // Branch from pc=5 to 0x0040
        step("br_req",   0, 1, 2'b10, 16'h0040, 16'h0000, 0, 1, 16'h0005, 16'h0005, 1, 0);
        step("br_fl1",   0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0040, 16'h0005, 0, 1);
        step("br_fl2",   0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0040, 16'h0005, 0, 1);
        step("br_fetch", 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0040, 16'h0005, 1, 0);

        // Register jump while stalled
        step("jr_req",   0, 1, 2'b01, 16'h0000, 16'h1234, 1, 1, 16'h0041, 16'h0041, 0, 0);
        step("jr_fl1",   0, 0, 2'b00, 16'h0000, 16'h0000, 1, 1, 16'h1234, 16'h0041, 0, 1);
        step("jr_fl2",   0, 0, 2'b00, 16'h0000, 16'h0000, 1, 1, 16'h1234, 16'h0041, 0, 1);
        step("jr_stall", 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 1, 16'h1234, 16'h0041, 0, 0);
        step("jr_go",    0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0041, 1, 0);

        // Back-to-back redirects, reserved select during and after flush
        step("b2b_br",   0, 1, 2'b10, 16'h0010, 16'h0000, 0, 0, 16'h1234, 16'h0041, 1, 0);
        step("b2b_jr",   0, 1, 2'b01, 16'h0099, 16'h0020, 0, 0, 16'h0010, 16'h0041, 0, 1);
        step("b2b_rsv",  0, 1, 2'b11, 16'h0099, 16'h0077, 0, 0, 16'h0020, 16'h0041, 0, 1);
        step("b2b_seq",  0, 1, 2'b00, 16'h0099, 16'h0077, 0, 0, 16'h0020, 16'h0041, 0, 1);
        step("rsv_fetch",0, 1, 2'b11, 16'h0099, 16'h0077, 0, 0, 16'h0020, 16'h0041, 1, 0);

        // Wait states at 0xFFFF and wrap
        step("wr_br",    0, 1, 2'b10, 16'hFFFF, 16'h0000, 0, 0, 16'h0020, 16'h0041, 1, 0);
        step("wr_fl1",   0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'h0041, 0, 1);
        step("wr_fl2",   0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'h0041, 0, 1);
        step("wr_wait1", 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'h0041, 1, 0);
        step("wr_wait2", 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'h0041, 1, 0);
        step("wr_wait3", 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'h0041, 1, 0);
        step("wr_acc",   0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'hFFFF, 16'h0041, 1, 0);
        step("wr_zero",  0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 1, 0);

        // Reset in the first flush cycle
        step("rf_jr",    0, 1, 2'b01, 16'h0000, 16'h0ABC, 0, 1, 16'h0001, 16'h0001, 1, 0);
        step("rf_fl1",   1, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0ABC, 16'h0001, 0, 1);
        step("rf_idle",  0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 0);
        step("rf_fetch", 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 1, 0);
        step("rf_next",  0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'h0001, 16'h0001, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the RISC-Z core: owns the PC register, issues fetch requests to instruction memory, and acts on the 2-bit PC-select code produced by branch control. It sits at the front of the pipeline. It converts each resolved select code into a next-PC choice plus a timed flush window that kills wrong-path instructions already in flight.

## Interface
- `PC_WIDTH`, 16, PC width in bits; word-addressed.
- `RESET_PC`, 0, PC value loaded on reset.
- `FLUSH_CYCLES`, 2, cycles of wrong-path kill after a redirect; legal range 1..7.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sel_valid` in 1: `pc_sel` and targets are valid this cycle.
- `pc_sel` in 2: 00 sequential, 10 branch target, 01 register jump, 11 reserved (treated as 00).
- `br_target` in PC_WIDTH: branch target address, used when `pc_sel`=10.
- `jr_target` in PC_WIDTH: register-jump address, used when `pc_sel`=01.
- `stall` in 1: hold PC and suppress new fetch requests.
- `fetch_ready` in 1: instruction memory accepts the current request.
- `fetch_req` out 1: fetch request for `pc`.
- `pc` out PC_WIDTH: current fetch address.
- `link_pc` out PC_WIDTH: address after the last accepted fetch (`pc`+1 at acceptance).
- `flush` out 1: kill the IF/ID-stage instructions this cycle.

## Operation
- Reset values: `pc`=RESET_PC, `link_pc`=RESET_PC, `fetch_req`=0, `flush`=0, state=IDLE, flush counter=0.
- States:
  - IDLE: one cycle after reset, then go to FETCH.
  - FETCH: `fetch_req` = !`stall`.
  - FLUSH: `fetch_req`=0 and `flush`=1.
- Redirect: `sel_valid` with `pc_sel` of 10 or 01, in any non-IDLE state, on any edge.
  - Next cycle: `pc` = selected target, counter = FLUSH_CYCLES, state = FLUSH.
- FLUSH: the counter decrements each cycle. When it reaches 1, go to FETCH on the next edge. `flush` is therefore high for exactly FLUSH_CYCLES cycles.
- Acceptance: `fetch_req`&&`fetch_ready` with no redirect in the same cycle.
  - Next cycle: `pc` = `pc`+1 and `link_pc` = `pc`+1.
- `fetch_req` high with `fetch_ready` low: `pc` holds. The request stays asserted unless `stall` rises or a redirect occurs. Withdrawal is permitted; instruction memory is a single-cycle responder.
- `pc_sel` 00 or 11, or `sel_valid`=0: no effect on the sequencer.
- Priority, highest first: `rst`, redirect, `stall`, handshake.
- `stall` does not block a redirect. A redirect while stalled still loads the target and enters FLUSH.
- Redirect inside FLUSH: load the new target, reload the counter to FLUSH_CYCLES, stay in FLUSH.
- Arithmetic: `pc`+1 is modulo 2^PC_WIDTH. All-ones wraps to 0 with no flag.
- Targets are used as-is, with no alignment or range check.
- Reset during FLUSH or with a pending request: all state returns to reset values on that edge, and the pending request is dropped.

## Timing
- Redirect latency:
  - `sel_valid` sampled at edge N.
  - `pc`=target and `flush`=1 from N+1 through N+FLUSH_CYCLES.
  - `fetch_req` for the target at N+FLUSH_CYCLES+1 (if not stalled).
- Sequential throughput: one fetch per cycle while `fetch_ready`=1 and `stall`=0.
- After `rst` deasserts: IDLE for 1 cycle, then the first `fetch_req` for RESET_PC.
- All outputs are registered except `fetch_req`, which is the state decode ANDed with !`stall`.

## Structure
- Shared package `riscz_pkg`:
  - PC-select encodings PCSEL_SEQ=2'b00, PCSEL_BR=2'b10, PCSEL_JR=2'b01, PCSEL_RSV=2'b11. These are shared with the branch-control block.
  - Sequencer state enum IDLE/FETCH/FLUSH.
- One natural sub-module, `pc_flush_timer`: a loadable down-counter that outputs `flush_active` and `flush_done`. The PC register and next-PC mux stay in the top level.

## Test plan
- Reset then run: `rst` 1 cycle, `fetch_ready`=1 → `pc` 0,0,1,2,3; `fetch_req` high from cycle 2; `link_pc` trails `pc` by one accepted fetch.
- Branch: `pc`=5, `sel_valid`=1, `pc_sel`=10, `br_target`=0x0040 → next `pc`=0x0040; `flush`=1 for 2 cycles; `fetch_req` for 0x0040 on the 3rd cycle.
- Register jump while stalled: `stall`=1, `pc_sel`=01, `jr_target`=0x1234 → `pc`=0x1234 and FLUSH entered; `fetch_req` stays 0 until `stall` drops after the flush ends.
- Back-to-back redirects: branch to 0x10, then 1 cycle later jump to 0x20 → `pc`=0x20 and `flush` high for 3 cycles total; reserved `pc_sel`=11 in between causes no redirect.
- Wait states and wrap: `pc`=0xFFFF, `fetch_ready` low 3 cycles → `pc` holds 0xFFFF with `fetch_req` high; on ready, `pc`=0x0000 and `link_pc`=0x0000.
- Reset mid-flush: assert `rst` in the 1st flush cycle → next cycle `pc`=0, `flush`=0, `fetch_req`=0, state IDLE.
